// File: rtl/issue_queue_param.sv
// Reservation-station issue queue with CDB operand capture and oldest-ready issue.
// Define ISSUE_QUEUE_OCC_EN to add the registered occupancy output.
module issue_queue_param #(
  parameter int DEPTH     = 8,
  parameter int TAG_W     = 4,
  parameter int DATA_W    = 32,
  parameter int PAYLOAD_W = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush,
  input  logic                 disp_valid,
  output logic                 disp_ready,
  input  logic [PAYLOAD_W-1:0] disp_payload,
  input  logic                 disp_rdy1,
  input  logic                 disp_rdy2,
  input  logic [TAG_W-1:0]     disp_tag1,
  input  logic [TAG_W-1:0]     disp_tag2,
  input  logic [DATA_W-1:0]    disp_val1,
  input  logic [DATA_W-1:0]    disp_val2,
  input  logic                 cdb_valid,
  input  logic [TAG_W-1:0]     cdb_tag,
  input  logic [DATA_W-1:0]    cdb_data,
  output logic                 issue_valid,
  input  logic                 issue_ready,
  output logic [PAYLOAD_W-1:0] issue_payload,
  output logic [DATA_W-1:0]    issue_op1,
  output logic [DATA_W-1:0]    issue_op2,
`ifdef ISSUE_QUEUE_OCC_EN
  output logic [$clog2(DEPTH+1)-1:0] occupancy,
`endif
  output logic                 empty,
  output logic                 full
);

  localparam int IDX_W = $clog2(DEPTH);

  logic [DEPTH-1:0]     valid_q;
  logic [DEPTH-1:0]     rdy1_q;
  logic [DEPTH-1:0]     rdy2_q;
  logic [TAG_W-1:0]     tag1_q [DEPTH];
  logic [TAG_W-1:0]     tag2_q [DEPTH];
  logic [DATA_W-1:0]    val1_q [DEPTH];
  logic [DATA_W-1:0]    val2_q [DEPTH];
  logic [PAYLOAD_W-1:0] pl_q   [DEPTH];
  // older_q[i][j] set means entry i was dispatched before entry j
  logic [DEPTH-1:0]     older_q [DEPTH];

  logic [DEPTH-1:0] elig;
  logic [DEPTH-1:0] sel;
  logic [IDX_W-1:0] free_idx;
  logic             free_found;
  logic             do_disp;
  logic             do_iss;
  logic             byp1;
  logic             byp2;

  assign empty       = ~|valid_q;
  assign full        = &valid_q;
  assign disp_ready  = ~full;
  assign elig        = valid_q & rdy1_q & rdy2_q;
  assign issue_valid = |elig;
  assign do_disp     = disp_valid && !full;
  assign do_iss      = issue_valid && issue_ready;
  assign byp1        = cdb_valid && (disp_tag1 == cdb_tag);
  assign byp2        = cdb_valid && (disp_tag2 == cdb_tag);

  always_comb begin
    sel = '0;
    for (int i = 0; i < DEPTH; i++) begin
      sel[i] = elig[i];
      for (int j = 0; j < DEPTH; j++) begin
        if (j != i && elig[j] && older_q[j][i]) sel[i] = 1'b0;
      end
    end
  end

  always_comb begin
    issue_payload = '0;
    issue_op1     = '0;
    issue_op2     = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (sel[i]) begin
        issue_payload = issue_payload | pl_q[i];
        issue_op1     = issue_op1 | val1_q[i];
        issue_op2     = issue_op2 | val2_q[i];
      end
    end
  end

  always_comb begin
    free_idx   = '0;
    free_found = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (!valid_q[i] && !free_found) begin
        free_idx   = IDX_W'(i);
        free_found = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      valid_q <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (do_iss && sel[i]) valid_q[i] <= 1'b0;
        if (valid_q[i] && cdb_valid) begin
          if (!rdy1_q[i] && tag1_q[i] == cdb_tag) begin
            rdy1_q[i] <= 1'b1;
            val1_q[i] <= cdb_data;
          end
          if (!rdy2_q[i] && tag2_q[i] == cdb_tag) begin
            rdy2_q[i] <= 1'b1;
            val2_q[i] <= cdb_data;
          end
        end
      end
      if (do_disp) begin
        valid_q[free_idx] <= 1'b1;
        pl_q[free_idx]    <= disp_payload;
        tag1_q[free_idx]  <= disp_tag1;
        tag2_q[free_idx]  <= disp_tag2;
        rdy1_q[free_idx]  <= disp_rdy1 || byp1;
        rdy2_q[free_idx]  <= disp_rdy2 || byp2;
        val1_q[free_idx]  <= (!disp_rdy1 && byp1) ? cdb_data : disp_val1;
        val2_q[free_idx]  <= (!disp_rdy2 && byp2) ? cdb_data : disp_val2;
        // new entry is younger than every other slot
        for (int j = 0; j < DEPTH; j++) begin
          older_q[free_idx][j] <= 1'b0;
          if (IDX_W'(j) != free_idx) older_q[j][free_idx] <= 1'b1;
        end
      end
    end
  end

`ifdef ISSUE_QUEUE_OCC_EN
  localparam int OCC_W = $clog2(DEPTH+1);

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      occupancy <= '0;
    end else begin
      occupancy <= occupancy + OCC_W'(do_disp) - OCC_W'(do_iss);
    end
  end
`endif

endmodule

// File: tb/tb_issue_queue_param.sv
// Randomised and directed checks of issue_queue_param against an
// in-order queue model of the reservation station.
module tb_issue_queue_param;

  localparam int DEPTH = 8;
  localparam int TAG_W = 4;
  localparam int DATA_W = 32;
  localparam int PW = 16;

  logic clk = 1'b0;
  logic rst, flush;
  logic disp_valid, disp_ready;
  logic [PW-1:0] disp_payload;
  logic disp_rdy1, disp_rdy2;
  logic [TAG_W-1:0] disp_tag1, disp_tag2;
  logic [DATA_W-1:0] disp_val1, disp_val2;
  logic cdb_valid;
  logic [TAG_W-1:0] cdb_tag;
  logic [DATA_W-1:0] cdb_data;
  logic issue_valid, issue_ready;
  logic [PW-1:0] issue_payload;
  logic [DATA_W-1:0] issue_op1, issue_op2;
  logic empty, full;
`ifdef ISSUE_QUEUE_OCC_EN
  logic [$clog2(DEPTH+1)-1:0] occupancy;
`endif

  always #5 clk = ~clk;

  issue_queue_param #(
    .DEPTH(DEPTH), .TAG_W(TAG_W), .DATA_W(DATA_W), .PAYLOAD_W(PW)
  ) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .disp_valid(disp_valid), .disp_ready(disp_ready),
    .disp_payload(disp_payload),
    .disp_rdy1(disp_rdy1), .disp_rdy2(disp_rdy2),
    .disp_tag1(disp_tag1), .disp_tag2(disp_tag2),
    .disp_val1(disp_val1), .disp_val2(disp_val2),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
    .issue_valid(issue_valid), .issue_ready(issue_ready),
    .issue_payload(issue_payload),
    .issue_op1(issue_op1), .issue_op2(issue_op2),
`ifdef ISSUE_QUEUE_OCC_EN
    .occupancy(occupancy),
`endif
    .empty(empty), .full(full)
  );

  typedef struct {
    logic [PW-1:0] pl;
    bit r1, r2;
    logic [TAG_W-1:0] t1, t2;
    logic [DATA_W-1:0] v1, v2;
  } ent_t;

  ent_t q[$];
  int vectors = 0;
  int miscompares = 0;

  task automatic cmp(string name, logic [63:0] act, logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int oldest_ready();
    int idx = -1;
    foreach (q[i]) if (idx < 0 && q[i].r1 && q[i].r2) idx = i;
    return idx;
  endfunction

  task automatic check_outputs();
    int idx = oldest_ready();
    cmp("empty", 64'(empty), 64'(q.size() == 0));
    cmp("full", 64'(full), 64'(q.size() == DEPTH));
    cmp("disp_ready", 64'(disp_ready), 64'(q.size() != DEPTH));
    cmp("issue_valid", 64'(issue_valid), 64'(idx >= 0));
    if (idx >= 0) begin
      cmp("issue_payload", 64'(issue_payload), 64'(q[idx].pl));
      cmp("issue_op1", 64'(issue_op1), 64'(q[idx].v1));
      cmp("issue_op2", 64'(issue_op2), 64'(q[idx].v2));
    end
`ifdef ISSUE_QUEUE_OCC_EN
    cmp("occupancy", 64'(occupancy), 64'(q.size()));
`endif
  endtask

  task automatic tick();
    int idx;
    int pre;
    ent_t e;
    check_outputs();
    idx = oldest_ready();
    pre = q.size();
    if (rst || flush) begin
      q.delete();
    end else begin
      if (idx >= 0 && issue_ready) q.delete(idx);
      if (cdb_valid) begin
        foreach (q[i]) begin
          if (!q[i].r1 && q[i].t1 == cdb_tag) begin
            q[i].r1 = 1; q[i].v1 = cdb_data;
          end
          if (!q[i].r2 && q[i].t2 == cdb_tag) begin
            q[i].r2 = 1; q[i].v2 = cdb_data;
          end
        end
      end
      if (disp_valid && pre < DEPTH) begin
        e.pl = disp_payload;
        e.t1 = disp_tag1; e.t2 = disp_tag2;
        e.r1 = disp_rdy1; e.r2 = disp_rdy2;
        e.v1 = disp_val1; e.v2 = disp_val2;
        if (!disp_rdy1 && cdb_valid && disp_tag1 == cdb_tag) begin
          e.r1 = 1; e.v1 = cdb_data;
        end
        if (!disp_rdy2 && cdb_valid && disp_tag2 == cdb_tag) begin
          e.r2 = 1; e.v2 = cdb_data;
        end
        q.push_back(e);
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle();
    rst = 0; flush = 0;
    disp_valid = 0; disp_payload = '0;
    disp_rdy1 = 0; disp_rdy2 = 0;
    disp_tag1 = '0; disp_tag2 = '0;
    disp_val1 = '0; disp_val2 = '0;
    cdb_valid = 0; cdb_tag = '0; cdb_data = '0;
    issue_ready = 0;
  endtask

  task automatic set_disp(logic [PW-1:0] pl, bit r1, logic [TAG_W-1:0] t1,
                          logic [DATA_W-1:0] v1, bit r2,
                          logic [TAG_W-1:0] t2, logic [DATA_W-1:0] v2);
    disp_valid = 1; disp_payload = pl;
    disp_rdy1 = r1; disp_tag1 = t1; disp_val1 = v1;
    disp_rdy2 = r2; disp_tag2 = t2; disp_val2 = v2;
  endtask

  initial begin
    idle();
    rst = 1;
    @(negedge clk);
    @(posedge clk);
    @(negedge clk);
    rst = 0;
    cmp("reset_empty", 64'(empty), 64'd1);
    cmp("reset_full", 64'(full), 64'd0);
    cmp("reset_issue_valid", 64'(issue_valid), 64'd0);

    // ready operands issue the cycle after dispatch
    set_disp(16'h0A1, 1, 4'd0, 32'd5, 1, 4'd0, 32'd7);
    tick();
    idle();
    cmp("rd_issue_valid", 64'(issue_valid), 64'd1);
    cmp("rd_op1", 64'(issue_op1), 64'd5);
    cmp("rd_op2", 64'(issue_op2), 64'd7);
    cmp("rd_payload", 64'(issue_payload), 64'h0A1);
    issue_ready = 1;
    tick();
    cmp("rd_empty_after", 64'(empty), 64'd1);

    // wakeup two cycles after dispatch
    idle();
    set_disp(16'h0B2, 0, 4'd3, 32'd0, 1, 4'd0, 32'd9);
    tick();
    idle();
    tick();
    cdb_valid = 1; cdb_tag = 4'd3; cdb_data = 32'h55;
    cmp("wk_not_yet", 64'(issue_valid), 64'd0);
    tick();
    idle();
    cmp("wk_issue_valid", 64'(issue_valid), 64'd1);
    cmp("wk_op1", 64'(issue_op1), 64'h55);
    issue_ready = 1;
    tick();

    // dispatch-cycle bypass
    idle();
    set_disp(16'h0C3, 0, 4'd3, 32'd0, 1, 4'd0, 32'd9);
    cdb_valid = 1; cdb_tag = 4'd3; cdb_data = 32'h66;
    tick();
    idle();
    cmp("byp_issue_valid", 64'(issue_valid), 64'd1);
    cmp("byp_op1", 64'(issue_op1), 64'h66);
    issue_ready = 1;
    tick();

    // fill, wake all together, drain in dispatch order
    idle();
    for (int i = 0; i < DEPTH; i++) begin
      set_disp(16'h200 + 16'(i), 0, 4'd2, 32'd0, 1, 4'd0, 32'(i));
      tick();
    end
    idle();
    cmp("ord_full", 64'(full), 64'd1);
    cmp("ord_disp_ready", 64'(disp_ready), 64'd0);
    cdb_valid = 1; cdb_tag = 4'd2; cdb_data = 32'h77;
    tick();
    idle();
    issue_ready = 1;
    for (int i = 0; i < DEPTH; i++) begin
      cmp("ord_payload", 64'(issue_payload), 64'h200 + 64'(i));
      tick();
    end
    cmp("ord_empty", 64'(empty), 64'd1);

    // backpressure then streaming pairs
    idle();
    set_disp(16'h50, 1, 4'd0, 32'd1, 1, 4'd0, 32'd1);
    tick();
    set_disp(16'h51, 1, 4'd0, 32'd2, 1, 4'd0, 32'd2);
    tick();
    idle();
    for (int i = 0; i < 3; i++) begin
      cmp("bp_stable", 64'(issue_payload), 64'h50);
      tick();
    end
    issue_ready = 1;
    for (int k = 0; k < 20; k++) begin
      set_disp(16'h100 + 16'(k), 1, 4'd0, 32'(k), 1, 4'd0, 32'(k));
      cmp("wrap_order", 64'(issue_payload),
          k < 2 ? 64'h50 + 64'(k) : 64'h100 + 64'(k - 2));
      tick();
    end
    disp_valid = 0;
    for (int k = 18; k < 20; k++) begin
      cmp("wrap_drain", 64'(issue_payload), 64'h100 + 64'(k));
      tick();
    end

    // flush with concurrent dispatch, issue and CDB
    idle();
    for (int i = 0; i < 5; i++) begin
      set_disp(16'h300 + 16'(i), 1, 4'd0, 32'(i), i < 2, 4'd9, 32'(i));
      tick();
    end
    set_disp(16'h3FF, 0, 4'd9, 32'd0, 1, 4'd0, 32'd0);
    issue_ready = 1;
    cdb_valid = 1; cdb_tag = 4'd9; cdb_data = 32'h99;
    flush = 1;
    tick();
    idle();
    cmp("fl_empty", 64'(empty), 64'd1);
    cmp("fl_issue_valid", 64'(issue_valid), 64'd0);
`ifdef ISSUE_QUEUE_OCC_EN
    cmp("fl_occupancy", 64'(occupancy), 64'd0);
`endif

    // random traffic
    for (int c = 0; c < 4000; c++) begin
      rst = ($urandom_range(0, 299) == 0);
      flush = ($urandom_range(0, 59) == 0);
      disp_valid = $urandom_range(0, 1);
      disp_payload = PW'($urandom);
      disp_rdy1 = ($urandom_range(0, 2) == 0);
      disp_rdy2 = ($urandom_range(0, 2) == 0);
      disp_tag1 = TAG_W'($urandom_range(0, 3));
      disp_tag2 = TAG_W'($urandom_range(0, 3));
      disp_val1 = $urandom;
      disp_val2 = $urandom;
      cdb_valid = ($urandom_range(0, 4) < 2);
      cdb_tag = TAG_W'($urandom_range(0, 4));
      cdb_data = $urandom;
      issue_ready = ($urandom_range(0, 4) < 3);
      tick();
    end
    idle();
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/issue_queue_param.md
Name: issue_queue_param

Overview:
- Parametrised reservation-station issue queue for the Tomasulo core.
- Successor to the fixed single-mode issue queue. Adds configurable depth and tag/data widths, operand capture from the CDB, and oldest-ready selection with an issue handshake.
- Sits between the dispatch/rename stage and one functional unit. Flushes on branch mispredict.

Parameters:
- DEPTH, 8, number of entries (power of two, at least 2)
- TAG_W, 4, ROB tag width
- DATA_W, 32, operand data width
- PAYLOAD_W, 16, opaque op/dest payload carried to the FU

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous active-high reset
- flush  in  1  synchronous; drop all entries
- disp_valid  in  1  dispatch request
- disp_ready  out  1  equals !full
- disp_payload  in  PAYLOAD_W  op/dest info
- disp_rdy1, disp_rdy2  in  1 each  operand already valid
- disp_tag1, disp_tag2  in  TAG_W each  producer tag when not ready
- disp_val1, disp_val2  in  DATA_W each  operand value when ready
- cdb_valid  in  1  result broadcast
- cdb_tag  in  TAG_W  broadcast tag
- cdb_data  in  DATA_W  broadcast value
- issue_valid  out  1  an entry has both operands ready
- issue_ready  in  1  FU accepts
- issue_payload  out  PAYLOAD_W  payload of the selected entry
- issue_op1, issue_op2  out  DATA_W each  operand values of the selected entry
- empty  out  1  no valid entries
- full  out  1  all DEPTH entries valid

Behaviour:
- Reset (rst=1 at a clock edge): all entry valid bits cleared; empty=1, full=0, issue_valid=0. Payload/operand outputs are don't-care while issue_valid=0. rst has priority over all other inputs.
- Dispatch accepted when disp_valid && disp_ready. The entry is written at the edge with a monotonic age stamp.
- disp_ready is !full from registered state. An issue in the same cycle does not free space for a same-cycle dispatch.
- CDB wakeup: at the edge, every valid entry with a waiting operand whose tag equals cdb_tag captures cdb_data and sets that operand ready.
- Dispatch bypass: a same-cycle dispatched operand with rdyN=0 and tagN==cdb_tag (cdb_valid=1) is captured as ready.
- Eligibility is evaluated from registered state only. An entry woken at edge T can issue in the cycle after T. There is no combinational CDB-to-issue path.
- Selection: the oldest eligible entry by age. issue_valid and the outputs are combinational from registered state and stay stable while issue_ready=0.
- Issue handshake: on issue_valid && issue_ready, the selected entry is invalidated at the edge.
- Age ordering must survive counter wrap-around. Use a relative-age matrix or a collapsing queue; a raw counter compare alone is insufficient.
- Simultaneous issue and dispatch: both take effect. Occupancy is unchanged.
- Simultaneous issue and CDB wakeup of the issued entry: the entry is removed; the capture is irrelevant.
- Flush: at the edge all entries are invalidated. A same-cycle dispatch and a same-cycle issue acceptance are both discarded. empty=1 the next cycle.
- Flush mid-wakeup: the CDB is ignored that cycle.
- empty and full are derived from registered valid bits. They are never both 1.

Optional Feature:
- Macro ISSUE_QUEUE_OCC_EN.
- When defined: adds output port occupancy [$clog2(DEPTH+1)-1:0], the registered count of valid entries.
  - Reset and flush set it to 0.
  - Dispatch adds +1, issue adds -1; both in the same cycle net to 0.
- When undefined: the port is absent and there is no counter logic.
- All other behaviour is identical in both builds.

Test Plan:
- Reset: rst=1 for 1 cycle, then 0 → empty=1, full=0, issue_valid=0.
- Ready dispatch: dispatch rdy1=rdy2=1, val1=5, val2=7, payload=0x0A1 → next cycle issue_valid=1, op1=5, op2=7, payload=0x0A1. With issue_ready=1, empty=1 the cycle after.
- Wakeup: dispatch rdy1=0, tag1=3, rdy2=1.
  - Cycle +2: cdb_valid, tag=3, data=0x55 → issue_valid=0 that cycle, 1 the next with op1=0x55.
  - Same stimulus but CDB in the dispatch cycle → bypass captured, issue_valid=1 the cycle after dispatch.
- Ordering: fill DEPTH=8 entries, all waiting on tag 2; full=1, disp_ready=0; broadcast tag 2 → entries issue in dispatch order, one per cycle, with issue_ready held 1.
- Backpressure and wrap: hold issue_ready=0 for 3 cycles → outputs stable. Then run 20 dispatch/issue pairs → strict age order is maintained across age wrap.
- Flush: 5 entries valid plus a same-cycle dispatch, flush=1 → next cycle empty=1, issue_valid=0. With ISSUE_QUEUE_OCC_EN defined, occupancy=0.
